ovl_fifo_index_driver: RTL and testbench
========================================

Name: ovl_fifo_index_driver

Overview:
- Stimulus-side counterpart of the FIFO-index checker.
- Generates legal multi-entry push/pop traffic for a FIFO of given depth, and tracks occupancy internally.
- Used in OVL self-test benches: drives the checker's push/pop inputs and real FIFOs under test.
- Pseudo-random traffic comes from an LFSR. Directed fill/drain modes and end-of-range flags are provided.

Parameters:
- depth, 4, FIFO capacity in entries; must be > 0. An elaboration error via ovl_error_t is raised if 0.
- push_width, 1, width of push count.
- pop_width, 1, width of pop count.
- simultaneous_push_pop, 1, 1 = push and pop may both be nonzero in one cycle; 0 = at most one is nonzero.
- seed, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  when 0: push = pop = 0; LFSR and state hold.
- fill_req  input  1  request FILL mode (sampled in RUN).
- drain_req  input  1  request DRAIN mode (sampled in RUN; fill_req wins if both are set).
- inject_err  input  1  single-cycle error-injection request (see Optional Feature).
- push  output  push_width  entries pushed this cycle (registered).
- pop  output  pop_width  entries popped this cycle (registered).
- fifo_used_depth  output  UW = `log(depth+1)  occupancy before this cycle's push/pop.
- full  output  1  fifo_used_depth == depth.
- empty  output  1  fifo_used_depth == 0.
- inj_ack  output  1  one-cycle pulse when an injection request was consumed.

Behaviour:
- Reset (asynchronous): push = 0, pop = 0, fifo_used_depth = 0, state = RUN, LFSR = seed, inj_ack = 0.
- Occupancy update, each posedge: used <= used + push - pop.
  - Computed at UW+1 bits, then saturated to the range [0, depth].
  - Saturation only matters during injection.
- push/pop registers load values computed from used_nxt (the occupancy after this edge). The values therefore appear the cycle after the decision, with zero bubble.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances once per enabled cycle.
  - Candidate push pc = lfsr[push_width-1:0].
  - Candidate pop oc = lfsr[pop_width+7:8] (bits wrap modulo 16).
  - Direction bit = lfsr[15].
- Legality clamp (always applied outside injection):
  - pop_nxt = min(oc, used_nxt).
  - push_nxt = min(pc, depth - used_nxt + pop_nxt).
  - If simultaneous_push_pop == 0: the direction bit selects push (1) or pop (0); the other count is forced to 0, and the pop term in the push clamp becomes 0.
- State machine:
  - RUN: random clamped traffic. fill_req -> FILL; else drain_req -> DRAIN.
  - FILL: pop = 0, push = min(2^push_width - 1, depth - used_nxt). -> RUN when used_nxt == depth.
  - DRAIN: push = 0, pop = min(2^pop_width - 1, used_nxt). -> RUN when used_nxt == 0.
  - If FILL is entered when already full, or DRAIN when already empty: one zero cycle is issued, then return to RUN.
- enable = 0 in any state: outputs 0, state holds, requests ignored.
- Reset asserted mid-FILL/DRAIN: immediate return to reset values; no partial transfer is reported.
- full/empty are combinational from the fifo_used_depth register.

Optional Feature:
- Macro: OVL_FIFO_DRV_ERR_INJ_EN.
- When defined, inject_err in RUN with enable = 1 causes the next cycle to present an illegal transfer, with inj_ack pulsing on that cycle:
  - Overflow: push = depth - used_nxt + 1 and pop = 0, if that value fits push_width.
  - Otherwise underflow: pop = used_nxt + 1 and push = 0, if that fits pop_width.
  - Otherwise push = pop = 0.
- Occupancy saturates afterwards.
- When the macro is undefined, inject_err is ignored and inj_ack is tied to 0.

Decomposition:
- Shared header std_ovl_defines holds:
  - the `log macro used for UW;
  - the state encodings OVL_FDRV_RUN = 2'd0, OVL_FDRV_FILL = 2'd1, OVL_FDRV_DRAIN = 2'd2;
  - the LFSR tap constant 16'hB400.
- One sub-module: ovl_lfsr16 (clk, reset_n, advance, seed, value), reusable by other OVL stimulus blocks.

Test Plan (depth = 4, push_width = 2, pop_width = 2 unless stated):
- Reset: reset_n low mid-cycle -> push = pop = 0, fifo_used_depth = 0, empty = 1 immediately, without waiting for clk.
- fill_req for 1 cycle from empty -> push = 3 then 1, used 0 -> 3 -> 4, full = 1, state back to RUN, pop = 0 throughout.
- drain_req at used = 4 -> pop = 3 then 1, used -> 1 -> 0, empty = 1, push = 0 throughout.
- 10k random cycles, both simultaneous_push_pop = 1 and 0 -> used always in 0..4; push = 0 or pop = 0 on every cycle when the parameter is 0; the companion checker fires no errors.
- enable = 0 for 5 cycles at used = 2 -> push = pop = 0, used stays 2, LFSR frozen; traffic resumes with the identical sequence.
- With OVL_FIFO_DRV_ERR_INJ_EN defined: inject_err at used_nxt = 2 -> push = 3, inj_ack = 1, checker reports overflow, used saturates at 4. With the macro undefined, the same stimulus gives inj_ack = 0 and no checker error.

Source files
------------

// File: rtl/ovl_fifo_index_driver_pkg.sv
// Shared OVL stimulus definitions: FIFO-driver state encodings, LFSR taps and sizing helpers.
// Used by ovl_fifo_index_driver and ovl_lfsr16.
package ovl_fifo_index_driver_pkg;

    typedef enum logic [1:0] {
        OVL_FDRV_RUN   = 2'd0,
        OVL_FDRV_FILL  = 2'd1,
        OVL_FDRV_DRAIN = 2'd2
    } ovl_fdrv_state_e;

    typedef enum logic [0:0] {
        OVL_ERR_NONE       = 1'b0,
        OVL_ERR_DEPTH_ZERO = 1'b1
    } ovl_error_t;

    localparam logic [15:0] OVL_LFSR16_TAPS      = 16'hB400;
    localparam logic [15:0] OVL_LFSR16_ZERO_SEED = 16'h0001;

    // Bits needed to hold values 0..n-1; never less than one bit so a bad depth still elaborates far enough to report.
    function automatic int ovl_log(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int ovl_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ovl_fifo_index_driver_lfsr.sv
// ovl_lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11) shared by the OVL stimulus blocks.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module ovl_lfsr16
    import ovl_fifo_index_driver_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? OVL_LFSR16_ZERO_SEED : seed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= seed_eff;
        end else if (advance) begin
            value <= (value >> 1) ^ (value[0] ? OVL_LFSR16_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/ovl_fifo_index_driver.sv
// ovl_fifo_index_driver: legal push/pop traffic generator for a FIFO of a given depth, with fill/drain modes.
// Define OVL_FIFO_DRV_ERR_INJ_EN to enable single-cycle overflow/underflow injection (inject_err / inj_ack).
module ovl_fifo_index_driver
    import ovl_fifo_index_driver_pkg::*;
#(
    parameter int          depth                 = 4,
    parameter int          push_width            = 1,
    parameter int          pop_width             = 1,
    parameter int          simultaneous_push_pop = 1,
    parameter logic [15:0] seed                  = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          fill_req,
    input  logic                          drain_req,
    input  logic                          inject_err,
    output logic [push_width-1:0]         push,
    output logic [pop_width-1:0]          pop,
    output logic [ovl_log(depth+1)-1:0]   fifo_used_depth,
    output logic                          full,
    output logic                          empty,
    output logic                          inj_ack
);

    localparam int UW       = ovl_log(depth + 1);
    localparam int MAX_PUSH = (1 << push_width) - 1;
    localparam int MAX_POP  = (1 << pop_width) - 1;

    localparam ovl_error_t CFG_ERR = (depth > 0) ? OVL_ERR_NONE : OVL_ERR_DEPTH_ZERO;

    generate
        if (CFG_ERR != OVL_ERR_NONE) begin : g_cfg_error
            $error("ovl_fifo_index_driver: depth must be greater than 0");
        end
    endgenerate

    ovl_fdrv_state_e       state_q;
    ovl_fdrv_state_e       state_nxt;
    ovl_fdrv_state_e       mode;
    logic [UW-1:0]         used_q;
    logic [push_width-1:0] push_q;
    logic [pop_width-1:0]  pop_q;
    logic                  inj_ack_q;
    logic                  inj_fire;
    logic [15:0]           lfsr_value;
    logic [pop_width-1:0]  oc_bits;
    int                    used_sum;
    int                    used_nxt;
    int                    pc;
    int                    oc;
    int                    push_nxt;
    int                    pop_nxt;

    ovl_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (enable),
        .seed    (seed),
        .value   (lfsr_value)
    );

    // Decisions are made from the occupancy after this edge, so the registered push/pop follow with no bubble.
    always_comb begin
        used_sum  = int'(used_q) + int'(push_q) - int'(pop_q);
        used_nxt  = (used_sum < 0) ? 0 : ((used_sum > depth) ? depth : used_sum);
        pc        = int'(lfsr_value[push_width-1:0]);
        oc_bits   = pop_width'({lfsr_value[7:0], lfsr_value[15:8]});
        oc        = int'(oc_bits);
        push_nxt  = 0;
        pop_nxt   = 0;
        state_nxt = state_q;
        inj_fire  = 1'b0;
        mode      = state_q;

        if (state_q == OVL_FDRV_RUN) begin
            if (fill_req) begin
                mode = OVL_FDRV_FILL;
            end else if (drain_req) begin
                mode = OVL_FDRV_DRAIN;
            end
        end
`ifdef OVL_FIFO_DRV_ERR_INJ_EN
        inj_fire = (state_q == OVL_FDRV_RUN) && inject_err;
`endif

        case (mode)
            OVL_FDRV_FILL: begin
                push_nxt  = ovl_min(MAX_PUSH, depth - used_nxt);
                state_nxt = (used_nxt == depth) ? OVL_FDRV_RUN : OVL_FDRV_FILL;
            end
            OVL_FDRV_DRAIN: begin
                pop_nxt   = ovl_min(MAX_POP, used_nxt);
                state_nxt = (used_nxt == 0) ? OVL_FDRV_RUN : OVL_FDRV_DRAIN;
            end
            default: begin
                state_nxt = OVL_FDRV_RUN;
                if (simultaneous_push_pop != 0) begin
                    pop_nxt  = ovl_min(oc, used_nxt);
                    push_nxt = ovl_min(pc, depth - used_nxt + pop_nxt);
                end else if (lfsr_value[15]) begin
                    push_nxt = ovl_min(pc, depth - used_nxt);
                end else begin
                    pop_nxt  = ovl_min(oc, used_nxt);
                end
            end
        endcase

        // Injection replaces this cycle's traffic and drops any fill/drain request seen alongside it.
        if (inj_fire) begin
            state_nxt = OVL_FDRV_RUN;
            push_nxt  = 0;
            pop_nxt   = 0;
            if (depth - used_nxt + 1 <= MAX_PUSH) begin
                push_nxt = depth - used_nxt + 1;
            end else if (used_nxt + 1 <= MAX_POP) begin
                pop_nxt = used_nxt + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= OVL_FDRV_RUN;
            used_q    <= '0;
            push_q    <= '0;
            pop_q     <= '0;
            inj_ack_q <= 1'b0;
        end else begin
            used_q <= UW'(used_nxt);
            if (enable) begin
                state_q   <= state_nxt;
                push_q    <= push_width'(push_nxt);
                pop_q     <= pop_width'(pop_nxt);
                inj_ack_q <= inj_fire;
            end else begin
                push_q    <= '0;
                pop_q     <= '0;
                inj_ack_q <= 1'b0;
            end
        end
    end

`ifndef OVL_FIFO_DRV_ERR_INJ_EN
    logic unused_inject_err;
    assign unused_inject_err = inject_err;
`endif

    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_value;

    assign push            = push_q;
    assign pop             = pop_q;
    assign fifo_used_depth = used_q;
    assign full            = (int'(used_q) == depth);
    assign empty           = (used_q == '0);
    assign inj_ack         = inj_ack_q;

endmodule

// File: tb/tb_ovl_fifo_index_driver.sv
// Directed bench for ovl_fifo_index_driver (depth 4, 2-bit counts), simultaneous and exclusive variants.
// Expected vectors come from hand-stepping the LFSR from seed 16'hACE1.
module tb_ovl_fifo_index_driver;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       fill_req;
    logic       drain_req;
    logic       inject_err;

    logic [1:0] sp_push, sp_pop, ns_push, ns_pop;
    logic [2:0] sp_used, ns_used;
    logic       sp_full, sp_empty, sp_inj_ack;
    logic       ns_full, ns_empty, ns_inj_ack;

    int n_compared = 0;
    int n_mismatch = 0;

    int sp_push_tab[8] = '{1, 0, 0, 0, 2, 3, 3, 1};
    int sp_pop_tab[8]  = '{0, 1, 0, 0, 0, 2, 3, 1};
    int sp_used_tab[8] = '{0, 1, 0, 0, 0, 2, 3, 3};
    int ns_push_tab[8] = '{1, 0, 0, 0, 0, 0, 3, 1};
    int ns_pop_tab[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    int ns_used_tab[8] = '{0, 1, 1, 0, 0, 0, 0, 3};

    int prev_sp_used, prev_sp_push, prev_sp_pop;
    int prev_ns_used, prev_ns_push, prev_ns_pop;

    ovl_fifo_index_driver #(
        .depth(4), .push_width(2), .pop_width(2), .simultaneous_push_pop(1), .seed(16'hACE1)
    ) dut_sp (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fill_req(fill_req),
        .drain_req(drain_req), .inject_err(inject_err), .push(sp_push), .pop(sp_pop),
        .fifo_used_depth(sp_used), .full(sp_full), .empty(sp_empty), .inj_ack(sp_inj_ack)
    );

    ovl_fifo_index_driver #(
        .depth(4), .push_width(2), .pop_width(2), .simultaneous_push_pop(0), .seed(16'hACE1)
    ) dut_ns (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fill_req(fill_req),
        .drain_req(drain_req), .inject_err(inject_err), .push(ns_push), .pop(ns_pop),
        .fifo_used_depth(ns_used), .full(ns_full), .empty(ns_empty), .inj_ack(ns_inj_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic en, input logic fill, input logic drain, input logic inj);
        enable     = en;
        fill_req   = fill;
        drain_req  = drain;
        inject_err = inj;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_sp(input string tag, input int e_push, input int e_pop, input int e_used);
        check_output({tag, "_push"}, 16'(sp_push), 16'(e_push));
        check_output({tag, "_pop"},  16'(sp_pop),  16'(e_pop));
        check_output({tag, "_used"}, 16'(sp_used), 16'(e_used));
    endtask

    initial begin
        // Reset state and first hand-computed random cycles for both variants.
        do_reset();
        check_sp("reset", 0, 0, 0);
        check_output("reset_empty", 16'(sp_empty), 16'd1);
        check_output("reset_full", 16'(sp_full), 16'd0);
        check_output("reset_inj_ack", 16'(sp_inj_ack), 16'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_sp($sformatf("sp_c%0d", k + 1), sp_push_tab[k], sp_pop_tab[k], sp_used_tab[k]);
            check_output($sformatf("ns_c%0d_push", k + 1), 16'(ns_push), 16'(ns_push_tab[k]));
            check_output($sformatf("ns_c%0d_pop", k + 1),  16'(ns_pop),  16'(ns_pop_tab[k]));
            check_output($sformatf("ns_c%0d_used", k + 1), 16'(ns_used), 16'(ns_used_tab[k]));
        end

        // Asynchronous reset in the middle of a cycle.
        #3;
        reset_n = 1'b0;
        #1;
        check_sp("async_rst", 0, 0, 0);
        check_output("async_rst_empty", 16'(sp_empty), 16'd1);

        // Fill from empty, drain from full, then drain request while already empty.
        tick();
        reset_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(); check_sp("fill1", 3, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_sp("fill2", 1, 0, 3);
        tick(); check_sp("fill3", 0, 0, 4);
        check_output("fill_full", 16'(sp_full), 16'd1);
        check_output("fill_not_empty", 16'(sp_empty), 16'd0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_sp("drain1", 0, 3, 4);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_sp("drain2", 0, 1, 1);
        tick(); check_sp("drain3", 0, 0, 0);
        check_output("drain_empty", 16'(sp_empty), 16'd1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(); check_sp("drain_at_empty", 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_sp("back_in_run", 1, 0, 0);

        // Enable low for five cycles at occupancy 2; traffic must resume where it stopped.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        check_sp("pre_hold", 2, 0, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_sp($sformatf("hold%0d", k), 0, 0, 2);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_sp("resume1", 3, 2, 2);
        tick(); check_sp("resume2", 3, 3, 3);
        tick(); check_sp("resume3", 1, 1, 3);

        // Injection request at occupancy-after-edge 2.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
`ifdef OVL_FIFO_DRV_ERR_INJ_EN
        check_sp("inj_c6", 3, 0, 2);
        check_output("inj_ack_c6", 16'(sp_inj_ack), 16'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_sp("inj_c7", 3, 3, 4);
        check_output("inj_full_c7", 16'(sp_full), 16'd1);
        check_output("inj_ack_c7", 16'(sp_inj_ack), 16'd0);
`else
        check_sp("inj_c6", 3, 2, 2);
        check_output("inj_ack_c6", 16'(sp_inj_ack), 16'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_sp("inj_c7", 3, 3, 3);
        check_output("inj_ack_c7", 16'(sp_inj_ack), 16'd0);
`endif

        // Long random run: occupancy tracks observed transfers exactly, exclusive variant never overlaps.
        do_reset();
        prev_sp_used = 0; prev_sp_push = 0; prev_sp_pop = 0;
        prev_ns_used = 0; prev_ns_push = 0; prev_ns_pop = 0;
        for (int k = 0; k < 10000; k++) begin
            apply_stimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                           ($urandom_range(0, 39) == 0), 1'b0);
            tick();
            check_output("rnd_sp_used", 16'(sp_used), 16'(prev_sp_used + prev_sp_push - prev_sp_pop));
            check_output("rnd_ns_used", 16'(ns_used), 16'(prev_ns_used + prev_ns_push - prev_ns_pop));
            check_output("rnd_ns_excl", 16'((ns_push == 2'd0) || (ns_pop == 2'd0)), 16'd1);
            check_output("rnd_sp_full", 16'(sp_full), 16'(sp_used == 3'd4));
            check_output("rnd_sp_empty", 16'(sp_empty), 16'(sp_used == 3'd0));
            prev_sp_used = int'(sp_used); prev_sp_push = int'(sp_push); prev_sp_pop = int'(sp_pop);
            prev_ns_used = int'(ns_used); prev_ns_push = int'(ns_push); prev_ns_pop = int'(ns_pop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
